// File: rtl/cp0_except_unit.sv
// cp0_except_unit: CP0 registers, MEM-stage exception resolution, flush/redirect and Count/Compare timer.
module cp0_except_unit #(
  parameter int          N_HWINT      = 6,
  parameter logic [31:0] EXC_VEC      = 32'hBFC0_0380,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic               m_valid,
  input  logic [7:0]         m_except,
  input  logic [31:0]        m_pc,
  input  logic               m_in_ds,
  input  logic [31:0]        m_data_addr,
  input  logic               mtc0_we,
  input  logic [4:0]         mtc0_addr,
  input  logic [31:0]        mtc0_wdata,
  input  logic [4:0]         mfc0_addr,
  output logic [31:0]        mfc0_rdata,
  output logic               flush,
  output logic [31:0]        flush_pc,
  output logic [4:0]         exc_code
);
  localparam logic [31:0] ST_MASK = 32'h0000_FF03;
  logic [31:0] badvaddr, count, compare, status, epc, cause;
  logic        bd, ti, tick;
  logic [5:0]  ip_hw, hw6;
  logic [1:0]  ip_sw;
  logic [4:0]  exccode, code;
  logic        int_req, exc, eret, wr, bad_pc, bad_da;
  assign hw6   = 6'(hw_int);
  assign cause = {bd, ti, 14'b0, ip_hw[5] | ti, ip_hw[4:0], ip_sw, 1'b0, exccode, 2'b0};
  assign int_req = (|(status[15:8] & cause[15:8])) && !status[1] && status[0];
  // Priority chain: interrupt, fetch AdEL, RI, Sys, Bp, Ov, load AdEL, store AdES
  always_comb begin
    code = int_req     ? 5'h00 :
           m_except[7] ? 5'h04 :
           m_except[3] ? 5'h0a :
           m_except[5] ? 5'h08 :
           m_except[6] ? 5'h09 :
           m_except[2] ? 5'h0c :
           m_except[1] ? 5'h04 : 5'h05;
    exc    = m_valid && (int_req || (|(m_except & 8'hEF)));
    eret   = m_valid && !exc && m_except[4];
    bad_pc = !int_req && m_except[7];
    bad_da = !int_req && !(|(m_except & 8'hEC)) && (|m_except[1:0]);
    wr     = mtc0_we && !exc && !eret;
    flush    = resetn && (exc || eret);
    flush_pc = !resetn ? 32'h0 : exc ? EXC_VEC : eret ? epc : 32'h0;
    exc_code = (resetn && exc) ? code : 5'h0;
    mfc0_rdata = mfc0_addr == 5'd8  ? badvaddr :
                 mfc0_addr == 5'd9  ? count :
                 mfc0_addr == 5'd11 ? compare :
                 mfc0_addr == 5'd12 ? status :
                 mfc0_addr == 5'd13 ? cause :
                 mfc0_addr == 5'd14 ? epc : 32'h0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      status   <= RESET_STATUS;
      epc      <= '0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      tick     <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      exccode  <= '0;
    end else begin
      tick     <= ~tick;
      ip_hw    <= hw6;
      count    <= (wr && mtc0_addr == 5'd9) ? mtc0_wdata : count + {31'b0, tick};
      compare  <= (wr && mtc0_addr == 5'd11) ? mtc0_wdata : compare;
      ti       <= (wr && mtc0_addr == 5'd11) ? 1'b0 : (ti || count == compare);
      status   <= exc  ? (status | 32'h2) :
                  eret ? (status & ~32'h2) :
                  (wr && mtc0_addr == 5'd12) ? ((status & ~ST_MASK) | (mtc0_wdata & ST_MASK)) : status;
      ip_sw    <= (wr && mtc0_addr == 5'd13) ? mtc0_wdata[9:8] : ip_sw;
      exccode  <= exc ? code : exccode;
      epc      <= (exc && !status[1]) ? (m_in_ds ? m_pc - 32'd4 : m_pc) :
                  (wr && mtc0_addr == 5'd14) ? mtc0_wdata : epc;
      bd       <= (exc && !status[1]) ? m_in_ds : bd;
      badvaddr <= (exc && bad_pc) ? m_pc : (exc && bad_da) ? m_data_addr : badvaddr;
    end
  end
endmodule
